// File: rtl/ws2812b_rx_decoder.sv
// ws2812b_rx_decoder
//
// Receive-side decoder for a single-wire WS2812B data stream. Each high
// pulse is measured in clock cycles and classified as a 0 or 1 bit. Bits are
// assembled MSB-first into 24-bit GRB words, presented on a valid/ready
// output. A low gap of T_RESET cycles after at least one completed word is
// reported as a frame latch, together with the number of words in that frame.
//
// Ports:
//   clk            clock
//   rst_n          synchronous, active-low reset
//   din_i          asynchronous serial input (2-flop synchronized internally)
//   rx_ready_i     consumer accepts rx_data_o this cycle
//   clear_flags_i  clears rx_overrun_o and rx_error_o (a same-cycle set wins)
//   rx_data_o      last completed word, first received bit at [23]
//   rx_valid_o     rx_data_o holds an unconsumed word
//   rx_latch_o     one-cycle pulse at the end of a reset gap closing a frame
//   led_count_o    completed words in the last latched frame (saturating)
//   rx_overrun_o   sticky: a completed word was dropped
//   rx_error_o     sticky: timing violation or partial word
module ws2812b_rx_decoder #(
  parameter int T_THRESH   = 38,
  parameter int T_MIN_HIGH = 8,
  parameter int T_MAX_HIGH = 96,
  parameter int T_RESET    = 3200,
  parameter int CNT_W      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_i,
  input  logic        rx_ready_i,
  input  logic        clear_flags_i,
  output logic [23:0] rx_data_o,
  output logic        rx_valid_o,
  output logic        rx_latch_o,
  output logic [7:0]  led_count_o,
  output logic        rx_overrun_o,
  output logic        rx_error_o
);

  // Line-decoder states.
  localparam logic [1:0] ST_SYNC = 2'd0;  // waiting for a full reset gap
  localparam logic [1:0] ST_IDLE = 2'd1;  // aligned, waiting for a bit
  localparam logic [1:0] ST_HIGH = 2'd2;  // measuring a high pulse
  localparam logic [1:0] ST_LOW  = 2'd3;  // measuring the low part of a bit

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(T_MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(T_RESET);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  localparam logic [4:0] LAST_BIT = 5'd23;

  // Saturating 8-bit increment for the per-frame word counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Bit classification from a measured high width.
  function automatic logic classify(input logic [CNT_W-1:0] width);
    return (width >= THRESH_C);
  endfunction

  // Sticky flag update: a set in the same cycle overrides a clear.
  function automatic logic sticky(input logic cur, input logic set, input logic clr);
    logic nxt;
    nxt = cur;
    if (clr) nxt = 1'b0;
    if (set) nxt = 1'b1;
    return nxt;
  endfunction

  // ---------------------------------------------------------------------
  // Input synchronizer and edge detection
  // ---------------------------------------------------------------------
  logic s1_q, s2_q, s2d_q;
  logic rise, fall;

  assign rise = s2_q & ~s2d_q;
  assign fall = ~s2_q & s2d_q;

  // ---------------------------------------------------------------------
  // Pulse measurement and bit assembly
  // ---------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [4:0]       bits_q, bits_d;
  logic [22:0]      shift_q, shift_d;

  logic             word_done;   // 24th bit decoded this cycle
  logic [23:0]      new_word;    // the completed word
  logic             err_set;     // timing violation or partial word
  logic             gap_end;     // reset gap completed in LOW

  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    new_word  = '0;
    err_set   = 1'b0;
    gap_end   = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (s2_q) begin
          cnt_d = '0;
        end else if (cnt_inc == RESET_C) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = ONE_C;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          if (cnt_q < MIN_C) begin
            err_set = 1'b1;
            bits_d  = '0;
            state_d = ST_SYNC;
            cnt_d   = '0;
          end else begin
            // The final bit completes the word straight from the shifter, so
            // the word is available in the same cycle the bit is decoded.
            if (bits_q == LAST_BIT) begin
              word_done = 1'b1;
              new_word  = {shift_q, classify(cnt_q)};
              bits_d    = '0;
            end else begin
              shift_d = {shift_q[21:0], classify(cnt_q)};
              bits_d  = bits_q + 5'd1;
            end
            state_d = ST_LOW;
            cnt_d   = ONE_C;
          end
        end else if (cnt_inc == MAX_C) begin
          err_set = 1'b1;
          bits_d  = '0;
          state_d = ST_SYNC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = ONE_C;
        end else if (cnt_inc == RESET_C) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gap_end = 1'b1;
          // Stale shifter contents need no clearing: a new word always
          // shifts 23 fresh bits through before it is used.
          if (bits_q != 5'd0) begin
            err_set = 1'b1;
            bits_d  = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
        bits_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output handshake, frame accounting and flags
  // ---------------------------------------------------------------------
  logic [23:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        latch_q, latch_d;
  logic [7:0]  frame_q, frame_d;
  logic [7:0]  led_q, led_d;
  logic        ovr_q, ovr_d;
  logic        err_q, err_d;
  logic        ovr_set;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    frame_d = frame_q;
    led_d   = led_q;
    latch_d = 1'b0;

    if (word_done) begin
      frame_d = sat_inc8(frame_q);
      // A consumer taking the old word this cycle frees the slot.
      if (!valid_q || rx_ready_i) begin
        data_d  = new_word;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end

    if (gap_end && (frame_q != 8'd0)) begin
      latch_d = 1'b1;
      led_d   = frame_q;
      frame_d = 8'd0;
    end

    ovr_d = sticky(ovr_q, ovr_set, clear_flags_i);
    err_d = sticky(err_q, err_set, clear_flags_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s2d_q   <= 1'b0;
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      latch_q <= 1'b0;
      frame_q <= 8'd0;
      led_q   <= 8'd0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= din_i;
      s2_q    <= s1_q;
      s2d_q   <= s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      latch_q <= latch_d;
      frame_q <= frame_d;
      led_q   <= led_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign rx_latch_o   = latch_q;
  assign led_count_o  = led_q;
  assign rx_overrun_o = ovr_q;
  assign rx_error_o   = err_q;

endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// Testbench for ws2812b_rx_decoder: directed sequence of random-width pulse
// trains; expected words come from classifying each sent high width.
module tb_ws2812b_rx_decoder;

  localparam int T_THRESH   = 38;
  localparam int T_MIN_HIGH = 8;
  localparam int T_MAX_HIGH = 96;
  localparam int T_RESET    = 3200;
  localparam int CNT_W      = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        rx_ready = 1'b0;
  logic        clear_flags = 1'b0;
  logic [23:0] rx_data;
  logic        rx_valid;
  logic        rx_latch;
  logic [7:0]  led_count;
  logic        rx_overrun;
  logic        rx_error;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed by the monitor.
  int          n_acc = 0;
  int          n_latch = 0;
  logic [23:0] last_acc = '0;

  // Expected by the model.
  int          exp_acc = 0;
  int          exp_latch = 0;
  logic [23:0] exp_w;

  // Pulse train to send: high widths and following low widths.
  int hi_q[$];
  int lo_q[$];

  ws2812b_rx_decoder #(
    .T_THRESH  (T_THRESH),
    .T_MIN_HIGH(T_MIN_HIGH),
    .T_MAX_HIGH(T_MAX_HIGH),
    .T_RESET   (T_RESET),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_i        (din),
    .rx_ready_i   (rx_ready),
    .clear_flags_i(clear_flags),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_latch_o   (rx_latch),
    .led_count_o  (led_count),
    .rx_overrun_o (rx_overrun),
    .rx_error_o   (rx_error)
  );

  always #5 clk = ~clk;

  // Monitor: count accepted words and latch-pulse cycles.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      n_acc    <= n_acc + 1;
      last_acc <= rx_data;
    end
    if (rx_latch) n_latch <= n_latch + 1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word value implied by the high widths in hi_q (MSB first).
  function automatic logic [23:0] model_word();
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < hi_q.size(); i++) w = {w[22:0], 1'(hi_q[i] >= T_THRESH)};
    return w;
  endfunction

  task automatic build_word(input logic [23:0] w, input bit nominal);
    hi_q.delete();
    lo_q.delete();
    for (int i = 23; i >= 0; i--) begin
      if (nominal) begin
        hi_q.push_back(w[i] ? 51 : 26);
        lo_q.push_back(w[i] ? 29 : 54);
      end else begin
        hi_q.push_back(w[i] ? int'($urandom_range(T_MAX_HIGH - 1, T_THRESH))
                            : int'($urandom_range(T_THRESH - 1, T_MIN_HIGH)));
        lo_q.push_back(int'($urandom_range(30, 5)));
      end
    end
  endtask

  task automatic truncate(input int n);
    while (hi_q.size() > n) begin
      void'(hi_q.pop_back());
      void'(lo_q.pop_back());
    end
  endtask

  // Sends hi_q/lo_q; returns one step after the final falling edge.
  task automatic send_seq();
    for (int i = 0; i < hi_q.size(); i++) begin
      din = 1'b1;
      repeat (hi_q[i]) step();
      din = 1'b0;
      if (i != hi_q.size() - 1) repeat (lo_q[i]) step();
    end
  endtask

  task automatic pulse(input int hi);
    din = 1'b1;
    repeat (hi) step();
    din = 1'b0;
  endtask

  task automatic clear_pulse();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
  endtask

  task automatic check_zero(input string p);
    check({p, "_data"},  32'(rx_data), 32'd0);
    check({p, "_valid"}, 32'(rx_valid), 32'd0);
    check({p, "_latch"}, 32'(rx_latch), 32'd0);
    check({p, "_led"},   32'(led_count), 32'd0);
    check({p, "_ovr"},   32'(rx_overrun), 32'd0);
    check({p, "_err"},   32'(rx_error), 32'd0);
  endtask

  // Random word sent and expected to be accepted (rx_ready high).
  task automatic word_ok(input string p);
    build_word(24'($urandom), 1'b0);
    exp_w = model_word();
    send_seq();
    repeat (10) step();
    exp_acc++;
    check({p, "_acc_cnt"}, 32'(n_acc), 32'(exp_acc));
    check({p, "_acc_data"}, 32'(last_acc), 32'(exp_w));
  endtask

  task automatic gap_latch(input string p, input int exp_led);
    repeat (T_RESET + 10) step();
    exp_latch++;
    check({p, "_latch_cnt"}, 32'(n_latch), 32'(exp_latch));
    check({p, "_led"}, 32'(led_count), 32'(exp_led));
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge clk);
    check_zero("rst");
    step();
    rst_n = 1'b1;
    repeat (T_RESET + 10) step();

    // Nominal word with exact output timing
    rx_ready = 1'b1;
    build_word(24'hA53CF0, 1'b1);
    send_seq();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("dec_valid_early", 32'(rx_valid), 32'd0);
    @(negedge clk);
    check("dec_valid", 32'(rx_valid), 32'd1);
    check("dec_data", 32'(rx_data), 32'hA53CF0);
    @(negedge clk);
    check("dec_valid_pulse", 32'(rx_valid), 32'd0);
    step();
    exp_acc++;
    check("dec_acc_cnt", 32'(n_acc), 32'(exp_acc));
    check("dec_acc_data", 32'(last_acc), 32'hA53CF0);
    repeat (10) step();

    // Overrun: second word dropped while the first is unconsumed
    rx_ready = 1'b0;
    build_word(24'h000001, 1'b0);
    send_seq();
    repeat (20) step();
    build_word(24'hFFFFFF, 1'b0);
    send_seq();
    repeat (20) step();
    @(negedge clk);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h000001);
    check("ovr_flag", 32'(rx_overrun), 32'd1);
    check("ovr_err", 32'(rx_error), 32'd0);
    step();
    clear_pulse();
    @(negedge clk);
    check("ovr_cleared", 32'(rx_overrun), 32'd0);
    step();
    rx_ready = 1'b1;
    step();
    @(negedge clk);
    check("ovr_valid_drop", 32'(rx_valid), 32'd0);
    step();
    exp_acc++;
    check("ovr_acc_cnt", 32'(n_acc), 32'(exp_acc));
    check("ovr_acc_data", 32'(last_acc), 32'h000001);

    // Frame latch after three completed words
    gap_latch("frm3", 3);

    // One-word frame with exact latch timing
    build_word(24'($urandom), 1'b0);
    exp_w = model_word();
    send_seq();
    repeat (T_RESET + 1) @(posedge clk);
    @(negedge clk);
    check("frm1_latch_early", 32'(rx_latch), 32'd0);
    @(negedge clk);
    check("frm1_latch", 32'(rx_latch), 32'd1);
    check("frm1_led", 32'(led_count), 32'd1);
    @(negedge clk);
    check("frm1_latch_pulse", 32'(rx_latch), 32'd0);
    step();
    exp_latch++;
    exp_acc++;
    check("frm1_latch_cnt", 32'(n_latch), 32'(exp_latch));
    check("frm1_acc_data", 32'(last_acc), 32'(exp_w));

    // Threshold boundaries inside a valid word: 37->0, 38->1, 8->0, 95->1
    build_word(24'($urandom), 1'b0);
    hi_q[0] = T_THRESH - 1;
    hi_q[1] = T_THRESH;
    hi_q[2] = T_MIN_HIGH;
    hi_q[3] = T_MAX_HIGH - 1;
    exp_w = model_word();
    send_seq();
    repeat (10) step();
    exp_acc++;
    check("thr_acc_cnt", 32'(n_acc), 32'(exp_acc));
    check("thr_acc_data", 32'(last_acc), 32'(exp_w));
    check("thr_top_bits", 32'(last_acc[23:20]), 32'h5);
    check("thr_err", 32'(rx_error), 32'd0);
    gap_latch("thr", 1);

    // Over-long high pulse: error, then resync gap required
    pulse(T_MAX_HIGH);
    repeat (20) step();
    @(negedge clk);
    check("max_err", 32'(rx_error), 32'd1);
    step();
    build_word(24'($urandom), 1'b0);
    send_seq();
    repeat (20) step();
    check("max_ignored_acc", 32'(n_acc), 32'(exp_acc));
    repeat (T_RESET + 10) step();
    check("max_no_latch", 32'(n_latch), 32'(exp_latch));
    word_ok("max_recover");
    gap_latch("max", 1);

    // Glitch shorter than the minimum high width
    clear_pulse();
    @(negedge clk);
    check("gl_err_clear", 32'(rx_error), 32'd0);
    step();
    pulse(T_MIN_HIGH - 1);
    repeat (20) step();
    @(negedge clk);
    check("gl_err", 32'(rx_error), 32'd1);
    step();
    repeat (T_RESET + 10) step();
    check("gl_no_latch", 32'(n_latch), 32'(exp_latch));
    clear_pulse();
    word_ok("gl_recover");
    gap_latch("gl", 1);

    // Partial word then a reset gap
    clear_pulse();
    build_word(24'($urandom), 1'b0);
    truncate(10);
    send_seq();
    repeat (T_RESET + 10) step();
    @(negedge clk);
    check("part_err", 32'(rx_error), 32'd1);
    check("part_valid", 32'(rx_valid), 32'd0);
    check("part_acc", 32'(n_acc), 32'(exp_acc));
    check("part_no_latch", 32'(n_latch), 32'(exp_latch));
    step();
    word_ok("part_recover");
    gap_latch("part", 1);

    // Reset asserted during bit 12
    build_word(24'($urandom), 1'b0);
    truncate(11);
    send_seq();
    repeat (15) step();
    din = 1'b1;
    repeat (20) step();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_zero("mid");
    step();
    rst_n = 1'b1;
    repeat (10) step();
    din = 1'b0;
    repeat (10) step();
    build_word(24'($urandom), 1'b0);
    truncate(6);
    send_seq();
    repeat (20) step();
    check("mid_ignored_acc", 32'(n_acc), 32'(exp_acc));
    repeat (T_RESET + 10) step();
    word_ok("mid_recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2812b_rx_decoder.md
# ws2812b_rx_decoder

Receive-side counterpart of the WS2812B strip driver. It samples a single-wire WS2812B data stream and measures each high pulse to classify it as a 0 or 1 bit. Bits are assembled MSB-first into 24-bit GRB words, and each completed word is presented on a valid/ready output. A low gap of at least the reset time is reported as a frame latch. Uses: loopback self-test of the TinyQV LED peripheral, and sniffing or forwarding an external strip chain from a PMOD input.

## Interface
Parameters:
- T_THRESH, 38: high-pulse cycles at or above which a bit decodes as 1 (64 MHz clock).
- T_MIN_HIGH, 8: high pulses shorter than this are glitches.
- T_MAX_HIGH, 96: a high pulse reaching this length is an error.
- T_RESET, 3200: consecutive low cycles that form a reset/latch gap (50 us).
- CNT_W, 12: width of the pulse counter; must hold T_RESET.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- din  in  1  asynchronous serial input; passes through an internal 2-flop synchronizer
- rx_ready  in  1  consumer accepts rx_data this cycle
- clear_flags  in  1  clears rx_overrun and rx_error
- rx_data  out  24  last completed word, GRB, first-received bit at [23]
- rx_valid  out  1  rx_data holds an unconsumed word
- rx_latch  out  1  one-cycle pulse at the end of a reset gap that follows at least one completed word
- led_count  out  8  completed words in the last latched frame, saturating at 255
- rx_overrun  out  1  sticky; a word was dropped
- rx_error  out  1  sticky; a timing violation or partial word occurred

## Operation
- Reset values: all outputs 0, state SYNC, counters 0.
- Synchronizer: din -> s1 -> s2. Edges are detected as s2 versus s2 delayed by one cycle.
- State machine:
  - SYNC: counts consecutive low cycles; any high clears the count. Count == T_RESET -> IDLE. No rx_latch is pulsed.
  - IDLE: rising edge -> HIGH, counter = 1.
  - HIGH: counter increments by 1 per cycle.
    - Falling edge with count < T_MIN_HIGH -> set rx_error, clear the bit counter, -> SYNC.
    - Otherwise decode the bit (count >= T_THRESH ? 1 : 0), shift it in, increment the bit counter, -> LOW with counter = 1.
    - Count reaching T_MAX_HIGH while still high -> set rx_error, clear the bit counter, -> SYNC.
  - LOW: rising edge -> HIGH, counter = 1.
    - Counter reaching T_RESET -> IDLE, and:
      - bit counter != 0 -> set rx_error and discard the partial bits;
      - frame word count != 0 -> pulse rx_latch, copy the frame count to led_count, clear the frame count.
- Word completion (bit counter reaches 24):
  - Bit counter resets to 0; frame count increments, saturating at 255.
  - rx_valid = 0, or rx_valid = 1 with rx_ready = 1 the same cycle: load rx_data, rx_valid = 1.
  - rx_valid = 1 with rx_ready = 0: keep the old rx_data, drop the new word, set rx_overrun.
- Handshake: rx_valid = 1 with rx_ready = 1 and no completion that cycle -> rx_valid = 0 next cycle. rx_ready while rx_valid = 0 has no effect.
- clear_flags: a flag being set in the same cycle wins over the clear.
- Reset mid-frame: all state is discarded, and a full T_RESET gap is required again before decoding resumes.

## Timing
- Latency din -> s2 is 2 cycles. Measured high width equals the din high width in cycles.
- rx_valid / rx_data update 3 cycles after the din falling edge of the 24th bit.
- rx_latch pulses T_RESET + 2 cycles after the last din falling edge. It is high for exactly 1 cycle; led_count updates in the same cycle.
- Back-to-back words at the nominal 80-cycle bit period are sustained with no gap.
- Counters saturate and never wrap.

## Test plan
- Decode a word: hold din low 3200 cycles after reset, then send 0xA53CF0 (0 bit = 26 high / 54 low, 1 bit = 51 high / 29 low), rx_ready = 1 -> rx_valid pulses for 1 cycle with rx_data = 0xA53CF0, 3 cycles after the last fall.
- Overrun: rx_ready = 0, send 0x000001 then 0xFFFFFF -> rx_data = 0x000001, rx_overrun = 1. Pulse clear_flags -> rx_overrun = 0. Raise rx_ready -> rx_valid drops.
- Frame latch: send 3 words, then low for 3200 cycles -> a single-cycle rx_latch and led_count = 3. A second frame of 1 word -> led_count = 1.
- Threshold boundaries: high 37 -> bit 0; high 38 -> bit 1; high 96 -> rx_error = 1 and a resync gap is required; high 7 -> rx_error = 1; high 8 -> valid bit 0.
- Partial word and glitch recovery: send 10 bits, then a 3200-cycle gap -> rx_error = 1, no rx_valid, no rx_latch. Next full word decodes correctly.
- Reset mid-word: assert rst_n low during bit 12 -> all outputs 0. Bits before a 3200-cycle low gap are ignored; the word after the gap decodes correctly.
